one_to_two_distributor: RTL and testbench
=========================================

# one_to_two_distributor

Streaming 1-to-2 data distributor: the inverse of the datapath two-input selector. A single 32-bit producer stream with valid/ready handshake is steered, beat by beat, by a per-beat `Control` bit into one of two independently buffered consumer streams. Each destination has its own `DEPTH`-entry FIFO, so a stalled consumer blocks only beats aimed at it. It sits between a producer (e.g. ALU/memory result path) and two downstream consumers (e.g. register write-back and store path).

## Interface
- `WIDTH`, 32, data beat width in bits
- `DEPTH`, 2, entries per destination FIFO; power of two, ≥2
- `CLK`  in  1  rising-edge clock
- `RST`  in  1  asynchronous, active-low reset
- `DataInput`  in  WIDTH  producer data beat
- `Control`  in  1  destination of the current beat: 0 → Zero side, 1 → One side
- `InValid`  in  1  producer has a beat on `DataInput`/`Control`
- `InReady`  out  1  distributor accepts the beat this cycle
- `ZeroOutput`  out  WIDTH  head of Zero FIFO
- `ZeroValid`  out  1  Zero FIFO non-empty
- `ZeroReady`  in  1  Zero consumer takes head this cycle
- `OneOutput`  out  WIDTH  head of One FIFO
- `OneValid`  out  1  One FIFO non-empty
- `OneReady`  in  1  One consumer takes head this cycle
- `ZeroCount`  out  clog2(DEPTH+1)  occupancy of Zero FIFO
- `OneCount`  out  clog2(DEPTH+1)  occupancy of One FIFO

## Operation
- Reset (`RST`=0, asynchronous): both FIFOs emptied, pointers and counts 0, storage cleared to 0. Outputs: `InReady`=0 while `RST`=0, `ZeroValid`=`OneValid`=0, `ZeroOutput`=`OneOutput`=0, counts 0.
- `InReady` = `RST` released AND (`Control`=0 ? `ZeroCount`<DEPTH : `OneCount`<DEPTH). Combinational on `Control` and registered counts only; never depends on `ZeroReady`/`OneReady` (no same-cycle pass-through into a full FIFO).
- Push: `InValid`&`InReady` at a rising edge writes `DataInput` into the FIFO selected by `Control`, advances its write pointer, count +1.
- Pop: `ZeroValid`&`ZeroReady` at a rising edge advances Zero read pointer, count −1; One side identical and independent.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance; legal when full (pop frees nothing for the push, which is already blocked by `InReady`=0) and when count=1.
- Pop with `Valid`=0 is ignored; `InValid`=0 with `InReady`=1 performs no push.
- Per-destination ordering strictly FIFO; no ordering relation between the two sides.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; full/empty decided by count, not pointer compare.
- `ZeroOutput`/`OneOutput` = storage at read pointer; value is don't-care when corresponding `Valid`=0, but must be stable while `Valid`=1 and `Ready`=0.
- Producer may change `Control` while `InValid`=1 and `InReady`=0; steering is evaluated each cycle (no lock).

## Timing
- Latency: beat accepted at edge N is visible on the selected output with `Valid`=1 after edge N (cycle N+1). No combinational input-to-output data path.
- Throughput: one beat per cycle per side when consumer holds `Ready`=1; sustained 1 beat/cycle into a side with DEPTH≥2.
- `Valid` deasserts after the edge that pops the last entry, unless a push to the same side occurs at that edge.
- Reset asserted mid-transfer: all in-flight and buffered beats discarded immediately; first edge after release sees empty FIFOs.

## Test plan
- Reset: hold `RST`=0 with `InValid`=1 → `InReady`=0, both `Valid`=0, outputs 0, counts 0; release → `InReady`=1.
- Steering: push 0xA5A5A5A5 with `Control`=0 then 0x5A5A5A5A with `Control`=1, both `Ready`=1 → each appears on its own port one cycle after acceptance, other side `Valid` stays 0.
- Backpressure/full: `ZeroReady`=0, push 3 beats 0x1,0x2,0x3 to Zero (DEPTH=2) → first two accepted, `ZeroCount`=2, `InReady`=0 for third; raising `ZeroReady` drains 0x1, 0x2 in order, then third accepted.
- Independence: Zero full and stalled, push 0x77 with `Control`=1 → accepted, `OneOutput`=0x77 next cycle.
- Simultaneous push/pop with count=1 on One side over 8 cycles, data 0x10..0x17 → `OneCount` stays 1, output order 0x10..0x17, pointer wrap exercised.
- Mid-operation reset with both FIFOs holding 2 entries → all `Valid`=0 asynchronously, counts 0, no stale beat after release.

Source files
------------

// File: rtl/one_to_two_distributor.sv
// Streaming 1-to-2 distributor: each producer beat is steered by Control into one of two
// independently buffered FIFOs, so a stalled consumer only blocks beats aimed at it.
module one_to_two_distributor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DataInput,
  input  logic             Control,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] ZeroOutput,
  output logic             ZeroValid,
  input  logic             ZeroReady,
  output logic [WIDTH-1:0] OneOutput,
  output logic             OneValid,
  input  logic             OneReady,
  output logic [CntW-1:0]  ZeroCount,
  output logic [CntW-1:0]  OneCount
);

  // Index 0 is the Zero side, index 1 the One side.
  logic [WIDTH-1:0] r_mem     [2][DEPTH];
  logic [PtrW-1:0]  r_wptr    [2];
  logic [PtrW-1:0]  r_rptr    [2];
  logic [CntW-1:0]  r_cnt     [2];
  logic [CntW-1:0]  w_cnt_nxt [2];
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic             w_in_ready;

  // Ready looks only at registered occupancy, never at the consumer Ready inputs.
  always_comb begin
    w_in_ready = RST && (Control ? (r_cnt[1] < CntW'(DEPTH)) : (r_cnt[0] < CntW'(DEPTH)));
    w_push     = {InValid && w_in_ready && Control, InValid && w_in_ready && !Control};
    w_pop      = {(r_cnt[1] != '0) && OneReady, (r_cnt[0] != '0) && ZeroReady};
    for (int s = 0; s < 2; s++) begin
      w_cnt_nxt[s] = r_cnt[s];
      case ({w_push[s], w_pop[s]})
        2'b10:   w_cnt_nxt[s] = r_cnt[s] + CntW'(1);
        2'b01:   w_cnt_nxt[s] = r_cnt[s] - CntW'(1);
        default: w_cnt_nxt[s] = r_cnt[s];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mem[s][i] <= '0;
        end
        r_wptr[s] <= '0;
        r_rptr[s] <= '0;
        r_cnt[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) begin
          r_mem[s][r_wptr[s]] <= DataInput;
          r_wptr[s]           <= r_wptr[s] + PtrW'(1);
        end
        if (w_pop[s]) begin
          r_rptr[s] <= r_rptr[s] + PtrW'(1);
        end
        r_cnt[s] <= w_cnt_nxt[s];
      end
    end
  end

  assign InReady    = w_in_ready;
  assign ZeroOutput = r_mem[0][r_rptr[0]];
  assign OneOutput  = r_mem[1][r_rptr[1]];
  assign ZeroValid  = (r_cnt[0] != '0);
  assign OneValid   = (r_cnt[1] != '0);
  assign ZeroCount  = r_cnt[0];
  assign OneCount   = r_cnt[1];

endmodule

// File: tb/tb_one_to_two_distributor.sv
// Bench for one_to_two_distributor: queue-based reference model checked every cycle,
// plus directed literal checks at the interesting points of each scenario.
module tb_one_to_two_distributor;

  localparam int unsigned Width = 32;
  localparam int unsigned Depth = 2;

  logic             clk;
  logic             rst_n;
  logic [Width-1:0] data_in;
  logic             ctrl;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] zero_out;
  logic             zero_valid;
  logic             zero_ready;
  logic [Width-1:0] one_out;
  logic             one_valid;
  logic             one_ready;
  logic [1:0]       zero_count;
  logic [1:0]       one_count;

  int n_checks = 0;
  int n_fail   = 0;

  one_to_two_distributor #(
    .WIDTH(Width),
    .DEPTH(Depth)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .DataInput (data_in),
    .Control   (ctrl),
    .InValid   (in_valid),
    .InReady   (in_ready),
    .ZeroOutput(zero_out),
    .ZeroValid (zero_valid),
    .ZeroReady (zero_ready),
    .OneOutput (one_out),
    .OneValid  (one_valid),
    .OneReady  (one_ready),
    .ZeroCount (zero_count),
    .OneCount  (one_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per destination.
  logic [Width-1:0] q0[$];
  logic [Width-1:0] q1[$];
  logic             m_rdy;
  logic             m_pop0;
  logic             m_pop1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      m_rdy  = ctrl ? (q1.size() < Depth) : (q0.size() < Depth);
      m_pop0 = (q0.size() > 0) && zero_ready;
      m_pop1 = (q1.size() > 0) && one_ready;
      if (m_pop0) void'(q0.pop_front());
      if (m_pop1) void'(q1.pop_front());
      if (in_valid && m_rdy) begin
        if (ctrl) q1.push_back(data_in);
        else      q0.push_back(data_in);
      end
    end
  end

  always @(negedge clk) begin
    chk("model_in_ready", 32'(in_ready),
        32'(rst_n && (ctrl ? (q1.size() < Depth) : (q0.size() < Depth))));
    chk("model_zero_valid", 32'(zero_valid), 32'(q0.size() > 0));
    chk("model_one_valid", 32'(one_valid), 32'(q1.size() > 0));
    chk("model_zero_count", 32'(zero_count), 32'(q0.size()));
    chk("model_one_count", 32'(one_count), 32'(q1.size()));
    if (q0.size() > 0) chk("model_zero_out", zero_out, q0[0]);
    if (q1.size() > 0) chk("model_one_out", one_out, q1[0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b1;
    data_in    = 32'hDEAD_BEEF;
    ctrl       = 1'b0;
    in_valid   = 1'b1;
    zero_ready = 1'b0;
    one_ready  = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with a pending beat
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_zero_valid", 32'(zero_valid), 32'd0);
    chk("rst_one_valid", 32'(one_valid), 32'd0);
    chk("rst_zero_out", zero_out, 32'd0);
    chk("rst_one_out", one_out, 32'd0);
    chk("rst_counts", 32'({zero_count, one_count}), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1 chk("release_in_ready", 32'(in_ready), 32'd1);

    // Steering
    cyc();
    zero_ready = 1'b1;
    one_ready  = 1'b1;
    in_valid   = 1'b1;
    ctrl       = 1'b0;
    data_in    = 32'hA5A5_A5A5;
    cyc();
    ctrl    = 1'b1;
    data_in = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("steer_zero_valid", 32'(zero_valid), 32'd1);
    chk("steer_zero_out", zero_out, 32'hA5A5_A5A5);
    chk("steer_one_idle", 32'(one_valid), 32'd0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("steer_one_valid", 32'(one_valid), 32'd1);
    chk("steer_one_out", one_out, 32'h5A5A_5A5A);
    chk("steer_zero_drained", 32'(zero_valid), 32'd0);
    cyc();

    // Backpressure on Zero, then independence of One
    zero_ready = 1'b0;
    in_valid   = 1'b1;
    ctrl       = 1'b0;
    data_in    = 32'h1;
    cyc();
    data_in = 32'h2;
    cyc();
    data_in = 32'h3;
    @(negedge clk);
    chk("full_zero_count", 32'(zero_count), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_zero_head", zero_out, 32'h1);
    cyc();
    ctrl    = 1'b1;
    data_in = 32'h77;
    @(negedge clk);
    chk("indep_in_ready", 32'(in_ready), 32'd1);
    cyc();
    ctrl       = 1'b0;
    data_in    = 32'h3;
    @(negedge clk);
    chk("indep_one_out", one_out, 32'h77);
    chk("indep_zero_held", zero_out, 32'h1);
    cyc();
    zero_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("drain_zero_head2", zero_out, 32'h2);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_third_head", zero_out, 32'h3);
    chk("drain_third_count", 32'(zero_count), 32'd1);
    cyc();

    // Simultaneous push/pop at count 1 on One, wrapping pointers
    one_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl      = 1'b1;
    data_in   = 32'h10;
    cyc();
    one_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      data_in = 32'h10 + 32'(k);
      cyc();
      @(negedge clk);
      chk("pp_one_count", 32'(one_count), 32'd1);
      chk("pp_one_out", one_out, 32'h10 + 32'(k));
    end
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("pp_one_empty", 32'(one_valid), 32'd0);

    // Mid-operation reset with both FIFOs full
    zero_ready = 1'b0;
    one_ready  = 1'b0;
    in_valid   = 1'b1;
    ctrl       = 1'b0;
    data_in    = 32'h21;
    cyc();
    data_in = 32'h22;
    cyc();
    ctrl    = 1'b1;
    data_in = 32'h31;
    cyc();
    data_in = 32'h32;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_counts", 32'({zero_count, one_count}), 32'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valids", 32'({zero_valid, one_valid}), 32'd0);
    chk("async_rst_counts", 32'({zero_count, one_count}), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_outs", zero_out | one_out, 32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    zero_ready = 1'b1;
    one_ready  = 1'b1;
    cyc();
    @(negedge clk);
    chk("post_rst_no_stale", 32'({zero_valid, one_valid}), 32'd0);
    in_valid = 1'b1;
    ctrl     = 1'b0;
    data_in  = 32'h99;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_fresh", zero_out, 32'h99);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
